// File: rtl/div_arbiter.sv
// div_arbiter: two-requester front end for one shared signed divider.
// A granted request is latched, divided by a WIDTH-step restoring divider on
// operand magnitudes, and the signed result is held until the consumer takes it.
// Optional feature macro: DIV_ARB_RR_EN selects round-robin arbitration between
// simultaneous requests; without it requester 0 has fixed priority.
module div_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_dividend,
    input  logic [WIDTH-1:0] req0_divisor,
    input  logic [WIDTH-1:0] req1_dividend,
    input  logic [WIDTH-1:0] req1_divisor,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_quotient,
    output logic [WIDTH-1:0] rsp_remainder,
    output logic             rsp_div0,
    output logic             rsp_ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic             id_q, neg_a_q, neg_b_q, div0_q, ovf_q;
    logic [WIDTH-1:0] a_q, dvs_q, acc_q, quo_q;
    logic             rsp_id_q, rsp_div0_q, rsp_ovf_q;
    logic [WIDTH-1:0] rsp_quo_q, rsp_rem_q;

    logic             any_v, gnt_id, accept, last_step;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH:0]   shifted, trial;
    logic             ge;
    logic [WIDTH-1:0] acc_d, quo_d, quo_fin, rem_fin;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    assign any_v = req0_valid | req1_valid;

`ifdef DIV_ARB_RR_EN
    // last_q = requester granted at the most recent acceptance; reset to 1 so 0 wins first
    logic last_q;
    assign gnt_id = (req0_valid & req1_valid) ? ~last_q : req1_valid;

    // Pointer moves only when a request is actually taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      last_q <= 1'b1;
        else if (accept) last_q <= gnt_id;
    end
`else
    assign gnt_id = ~req0_valid;
`endif

    assign accept    = (state_q == IDLE) & any_v;
    assign last_step = (cnt_q == CW'(WIDTH - 1));
    assign op_a      = gnt_id ? req1_dividend : req0_dividend;
    assign op_b      = gnt_id ? req1_divisor  : req0_divisor;

    // One restoring step: shift next dividend bit into the partial remainder, try subtract
    always_comb begin
        shifted = {acc_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        ge      = ~trial[WIDTH];
        acc_d   = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], ge};
    end

    // Re-apply signs (truncate toward zero, remainder follows dividend) and special cases
    always_comb begin
        quo_fin = (neg_a_q ^ neg_b_q) ? (~quo_d + 1'b1) : quo_d;
        rem_fin = neg_a_q ? (~acc_d + 1'b1) : acc_d;
        if (div0_q) begin
            quo_fin = '0;
            rem_fin = a_q;
        end else if (ovf_q) begin
            quo_fin = MIN_VAL;
            rem_fin = '0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and handshake outputs
    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                req0_ready = req0_valid & ~gnt_id;
                req1_ready = req1_valid &  gnt_id;
                if (any_v) state_d = CALC;
            end
            CALC: if (last_step) state_d = DONE;
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, iteration, and result registers loaded on the final step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            id_q       <= 1'b0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            div0_q     <= 1'b0;
            ovf_q      <= 1'b0;
            a_q        <= '0;
            dvs_q      <= '0;
            acc_q      <= '0;
            quo_q      <= '0;
            rsp_id_q   <= 1'b0;
            rsp_div0_q <= 1'b0;
            rsp_ovf_q  <= 1'b0;
            rsp_quo_q  <= '0;
            rsp_rem_q  <= '0;
        end else if (accept) begin
            cnt_q   <= '0;
            id_q    <= gnt_id;
            a_q     <= op_a;
            neg_a_q <= op_a[WIDTH-1];
            neg_b_q <= op_b[WIDTH-1];
            dvs_q   <= mag(op_b);
            acc_q   <= '0;
            quo_q   <= mag(op_a);
            div0_q  <= (op_b == '0);
            ovf_q   <= (op_a == MIN_VAL) && (op_b == '1);
        end else if (state_q == CALC) begin
            cnt_q <= cnt_q + 1'b1;
            acc_q <= acc_d;
            quo_q <= quo_d;
            if (last_step) begin
                rsp_id_q   <= id_q;
                rsp_quo_q  <= quo_fin;
                rsp_rem_q  <= rem_fin;
                rsp_div0_q <= div0_q;
                rsp_ovf_q  <= ovf_q;
            end
        end
    end

    assign rsp_id        = rsp_id_q;
    assign rsp_quotient  = rsp_quo_q;
    assign rsp_remainder = rsp_rem_q;
    assign rsp_div0      = rsp_div0_q;
    assign rsp_ovf       = rsp_ovf_q;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: scoreboard bench for div_arbiter (WIDTH = 4).
// Expected results are computed from the operands of each observed acceptance
// using native signed int division and pushed to a queue; responses pop it.
module tb_div_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         v0 = 1'b0, v1 = 1'b0, r0, r1;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         rv, rr = 1'b1, rid, rd0, rov;
    logic [W-1:0] rq, rrem;

    typedef struct {
        int id;
        int q;
        int r;
        int d0;
        int ov;
    } exp_t;

    exp_t   sb[$];
    exp_t   e;
    int     n_chk = 0, n_pass = 0, cyc = 0, acc_cyc = 0, n_pop = 0, m_last = 1;
    logic   rv_p = 1'b0, rr_p = 1'b0, id_p = 1'b0;
    logic [W-1:0] q_p = '0, r_p = '0;

    div_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req1_valid(v1),
        .req0_ready(r0), .req1_ready(r1),
        .req0_dividend(a0), .req0_divisor(b0),
        .req1_dividend(a1), .req1_divisor(b1),
        .rsp_valid(rv), .rsp_ready(rr), .rsp_id(rid),
        .rsp_quotient(rq), .rsp_remainder(rrem),
        .rsp_div0(rd0), .rsp_ovf(rov)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic exp_t model(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t x;
        int sa, sb_;
        sa   = int'($signed(a));
        sb_  = int'($signed(b));
        x.id = id; x.d0 = 0; x.ov = 0;
        if (sb_ == 0) begin
            x.q = 0; x.r = sa; x.d0 = 1;
        end else if (sa == -(1 << (W-1)) && sb_ == -1) begin
            x.q = sa; x.r = 0; x.ov = 1;
        end else begin
            x.q = sa / sb_; x.r = sa % sb_;
        end
        return x;
    endfunction

    // Monitor: sample mid-cycle; acceptances push, response handshakes pop
    always @(negedge clk) begin
        if (rst_n) begin
            if (r0 | r1) begin
                int g;
`ifdef DIV_ARB_RR_EN
                g = (v0 && v1) ? (1 - m_last) : (v1 ? 1 : 0);
                m_last = g;
`else
                g = v0 ? 0 : 1;
`endif
                chk("grant", int'(r1), g);
                sb.push_back(g ? model(1, a1, b1) : model(0, a0, b0));
                acc_cyc = cyc + 1;
            end
            if (rv && !rv_p) chk("latency", cyc - acc_cyc, W);
            if (rv && rv_p && !rr_p) begin
                chk("hold_q", int'(rq), int'(q_p));
                chk("hold_r", int'(rrem), int'(r_p));
                chk("hold_id", int'(rid), int'(id_p));
            end
            if (rv) chk("busy_rdy", int'(r0 | r1), 0);
            if (rv && rr) begin
                if (sb.size() == 0) chk("spurious_rsp", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("id", int'(rid), e.id);
                    chk("quot", int'($signed(rq)), e.q);
                    chk("rem", int'($signed(rrem)), e.r);
                    chk("div0", int'(rd0), e.d0);
                    chk("ovf", int'(rov), e.ov);
                    n_pop++;
                end
            end
            rv_p = rv; rr_p = rr; q_p = rq; r_p = rrem; id_p = rid;
        end else begin
            rv_p = 1'b0;
        end
    end

    task automatic issue(input int who, input int a, input int b);
        @(posedge clk); #1;
        if (who == 0) begin v0 = 1'b1; a0 = W'(a); b0 = W'(b); end
        else          begin v1 = 1'b1; a1 = W'(a); b1 = W'(b); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((who == 0) ? r0 : r1) begin
                @(posedge clk); #1;
                if (who == 0) v0 = 1'b0; else v1 = 1'b0;
                return;
            end
        end
        chk("accept_timeout", 0, 1);
        v0 = 1'b0; v1 = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !rv) return;
        end
        chk("drain_timeout", 0, 1);
    endtask

    task automatic chk_reset_outs();
        chk("rst_valid", int'(rv), 0);
        chk("rst_id", int'(rid), 0);
        chk("rst_q", int'(rq), 0);
        chk("rst_r", int'(rrem), 0);
        chk("rst_div0", int'(rd0), 0);
        chk("rst_ovf", int'(rov), 0);
    endtask

    initial begin
        int p0;
        #1 rst_n = 1'b0;
        #2 chk_reset_outs();
        chk("rst_rdy", int'(r0 | r1), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // single request, remainder-only result
        issue(0, 5, 8);
        drain();

        // signed sign rules, one per requester
        issue(1, -7, 3);
        issue(0, 7, -3);
        drain();

        // divide by zero and most-negative / -1 overflow
        issue(0, 5, 0);
        issue(1, -8, -1);
        drain();

        // consumer stalls in DONE; competing request must wait
        rr = 1'b0;
        issue(0, 3, 2);
        for (int i = 0; i < 20 && !rv; i++) @(negedge clk);
        chk("stall_valid", int'(rv), 1);
        @(posedge clk); #1;
        v1 = 1'b1; a1 = W'(6); b1 = W'(-4);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rdy_after_done", int'(r1), 1);
        @(posedge clk); #1 v1 = 1'b0;
        drain();

        // reset while calculating; 4'(-9) wraps to 7
        issue(0, -9, -3);
        @(posedge clk); #2 rst_n = 1'b0;
        #1 chk_reset_outs();
        sb.delete();
        m_last = 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 3) @(negedge clk);
        chk("no_rsp_after_rst", int'(rv), 0);
        issue(0, 7, 7);
        drain();

        // both requesters held valid for four results; 4'(10) wraps to -6
        @(posedge clk); #1;
        v0 = 1'b1; a0 = W'(10); b0 = W'(2);
        v1 = 1'b1; a1 = W'(-8); b1 = W'(1);
        p0 = n_pop;
        for (int i = 0; i < 200 && n_pop < p0 + 4; i++) @(negedge clk);
        chk("contend_count", n_pop - p0, 4);
        @(posedge clk); #1 v0 = 1'b0; v1 = 1'b0;
        drain();

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
